// File: rtl/lif_pkg.sv
// -----------------------------------------------------------------------------
// lif_pkg
// Definitions shared across the multi-neuron LIF datapath:
//   - FSM state encoding for the membrane update block
//   - default membrane/sum width and neuron index width, also used by the
//     upstream score accumulator so both ends agree on the bus widths
// -----------------------------------------------------------------------------
package lif_pkg;

    localparam int VMEM_W_DEF = 16;
    localparam int NID_W_DEF  = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAK  = 3'd1,
        ST_INTEG = 3'd2,
        ST_FIRE  = 3'd3,
        ST_EMIT  = 3'd4
    } lif_state_e;

endpackage

// File: rtl/lif_membrane_update_if.sv
// -----------------------------------------------------------------------------
// lif_membrane_update_if
// Bundles the two handshakes of the membrane update block:
//   acc_done/acc_sum/acc_nid     : finished sum from the score accumulator
//   spike_valid/spike_nid/ready  : spike event towards the downstream consumer
// Modports:
//   master : the environment (drives accumulator side, accepts spikes)
//   slave  : the membrane update block
// -----------------------------------------------------------------------------
interface lif_membrane_update_if #(
    parameter int VMEM_W = lif_pkg::VMEM_W_DEF,
    parameter int NID_W  = lif_pkg::NID_W_DEF
) ();

    logic              acc_done;
    logic [VMEM_W-1:0] acc_sum;
    logic [NID_W-1:0]  acc_nid;
    logic              spike_valid;
    logic [NID_W-1:0]  spike_nid;
    logic              spike_ready;

    modport master (
        output acc_done,
        output acc_sum,
        output acc_nid,
        output spike_ready,
        input  spike_valid,
        input  spike_nid
    );

    modport slave (
        input  acc_done,
        input  acc_sum,
        input  acc_nid,
        input  spike_ready,
        output spike_valid,
        output spike_nid
    );

endinterface

// File: rtl/lif_leak_integrate.sv
// -----------------------------------------------------------------------------
// lif_leak_integrate
// Purely combinational leak and saturating integrate for one membrane value.
// Ports:
//   v_in    : current membrane potential
//   sum_in  : accumulated input to integrate
//   v_leak  : v_in - (v_in >> LEAK_SHIFT); logical shift so it cannot underflow
//   v_integ : min(v_in + sum_in, 2^VMEM_W-1)
// -----------------------------------------------------------------------------
module lif_leak_integrate #(
    parameter int VMEM_W     = lif_pkg::VMEM_W_DEF,
    parameter int LEAK_SHIFT = 3
) (
    input  logic [VMEM_W-1:0] v_in,
    input  logic [VMEM_W-1:0] sum_in,
    output logic [VMEM_W-1:0] v_leak,
    output logic [VMEM_W-1:0] v_integ
);

    logic [VMEM_W:0] sum_ext;

    assign v_leak  = v_in - (v_in >> LEAK_SHIFT);

    // One extra bit catches the carry; a set carry means clamp to all-ones.
    assign sum_ext = {1'b0, v_in} + {1'b0, sum_in};
    assign v_integ = sum_ext[VMEM_W] ? {VMEM_W{1'b1}} : sum_ext[VMEM_W-1:0];

endmodule

// File: rtl/lif_membrane_update.sv
// -----------------------------------------------------------------------------
// lif_membrane_update
// Consumes finished sums from the score accumulator, updates the addressed
// neuron's membrane potential (leak, saturating integrate, threshold compare)
// and emits a spike event when the neuron fires.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   threshold   : firing threshold, sampled in FIRE
//   clear_all   : in IDLE, zero every membrane value and the overrun flag
//   busy        : FSM is not in IDLE
//   overrun     : sticky, an acc_done pulse arrived while busy and was dropped
//   vmem_dbg    : value written back by the most recent update
//   lif_bus     : accumulator input and spike output handshakes
// Update of a sum presented in cycle T: LEAK T+1, INTEG T+2, FIRE/write-back
// at the end of T+3, spike_valid from T+4.
// -----------------------------------------------------------------------------
module lif_membrane_update
    import lif_pkg::*;
#(
    parameter int NUM_NEURONS = 8,
    parameter int NID_W       = NID_W_DEF,
    parameter int VMEM_W      = VMEM_W_DEF,
    parameter int LEAK_SHIFT  = 3,
    parameter bit RESET_SUB   = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [VMEM_W-1:0] threshold,
    input  logic              clear_all,
    output logic              busy,
    output logic              overrun,
    output logic [VMEM_W-1:0] vmem_dbg,
    lif_membrane_update_if.slave lif_bus
);

    lif_state_e        state_reg;
    logic [VMEM_W-1:0] sum_reg;
    logic [NID_W-1:0]  id_reg;
    logic [VMEM_W-1:0] v_reg;
    logic              spike_valid_reg;
    logic [NID_W-1:0]  spike_nid_reg;
    logic              overrun_reg;
    logic [VMEM_W-1:0] vmem_dbg_reg;

    logic [VMEM_W-1:0] vmem_reg [NUM_NEURONS];

    logic [VMEM_W-1:0] v_leak;
    logic [VMEM_W-1:0] v_integ;
    logic              fire;
    logic [VMEM_W-1:0] wb_data;
    logic              wr_en;
    logic              clear_en;

    lif_leak_integrate #(
        .VMEM_W     (VMEM_W),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) u_leak_integrate (
        .v_in    (v_reg),
        .sum_in  (sum_reg),
        .v_leak  (v_leak),
        .v_integ (v_integ)
    );

    assign fire     = (v_reg >= threshold);
    assign wr_en    = (state_reg == ST_FIRE);
    // Clear only acts in IDLE so it can never race an in-flight write-back.
    assign clear_en = (state_reg == ST_IDLE) && clear_all;

    always_comb begin
        wb_data = v_reg;
        if (fire) begin
            wb_data = RESET_SUB ? (v_reg - threshold) : '0;
        end
    end

    // Membrane register file. Capture only happens in IDLE, after any
    // previous write-back has landed, so reads never need a bypass.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (!rst_n || clear_en) begin
                vmem_reg[i] <= '0;
            end else if (wr_en && (id_reg == NID_W'(i))) begin
                vmem_reg[i] <= wb_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            sum_reg         <= '0;
            id_reg          <= '0;
            v_reg           <= '0;
            spike_valid_reg <= 1'b0;
            spike_nid_reg   <= '0;
            overrun_reg     <= 1'b0;
            vmem_dbg_reg    <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    // Clear takes precedence: a coincident acc_done is
                    // discarded and the flag still ends up cleared.
                    if (clear_all) begin
                        overrun_reg <= 1'b0;
                    end else if (lif_bus.acc_done) begin
                        sum_reg   <= lif_bus.acc_sum;
                        id_reg    <= lif_bus.acc_nid;
                        v_reg     <= vmem_reg[lif_bus.acc_nid];
                        state_reg <= ST_LEAK;
                    end
                end
                ST_LEAK: begin
                    v_reg     <= v_leak;
                    state_reg <= ST_INTEG;
                end
                ST_INTEG: begin
                    v_reg     <= v_integ;
                    state_reg <= ST_FIRE;
                end
                ST_FIRE: begin
                    vmem_dbg_reg <= wb_data;
                    if (fire) begin
                        spike_valid_reg <= 1'b1;
                        spike_nid_reg   <= id_reg;
                        state_reg       <= ST_EMIT;
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_EMIT: begin
                    if (lif_bus.spike_ready) begin
                        spike_valid_reg <= 1'b0;
                        state_reg       <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase

            if ((state_reg != ST_IDLE) && lif_bus.acc_done) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    assign busy                = (state_reg != ST_IDLE);
    assign overrun             = overrun_reg;
    assign vmem_dbg            = vmem_dbg_reg;
    assign lif_bus.spike_valid = spike_valid_reg;
    assign lif_bus.spike_nid   = spike_nid_reg;

endmodule

// File: tb/tb_lif_membrane_update.sv
// -----------------------------------------------------------------------------
// tb_lif_membrane_update
// Directed bench for lif_membrane_update with RESET_SUB=0, LEAK_SHIFT=3,
// 8 neurons of 16 bits. Expected values are computed by hand in the comments.
// -----------------------------------------------------------------------------
module tb_lif_membrane_update;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear_all = 1'b0;
    logic [15:0] threshold = '0;
    logic        busy;
    logic        overrun;
    logic [15:0] vmem_dbg;

    int n_vec = 0;
    int n_err = 0;

    lif_membrane_update_if #(.VMEM_W(16), .NID_W(3)) bus ();

    lif_membrane_update #(
        .NUM_NEURONS (8),
        .NID_W       (3),
        .VMEM_W      (16),
        .LEAK_SHIFT  (3),
        .RESET_SUB   (1'b0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .threshold (threshold),
        .clear_all (clear_all),
        .busy      (busy),
        .overrun   (overrun),
        .vmem_dbg  (vmem_dbg),
        .lif_bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Present acc_done for one cycle (cycle T); returns in T+1.
    task automatic start_update(input logic [2:0] nid, input logic [15:0] sum,
                                input logic [15:0] thr);
        bus.acc_done = 1'b1;
        bus.acc_nid  = nid;
        bus.acc_sum  = sum;
        threshold    = thr;
        tick();
        bus.acc_done = 1'b0;
    endtask

    // Full update; returns in T+4 with write-back done and any spike visible.
    task automatic run_update(input logic [2:0] nid, input logic [15:0] sum,
                              input logic [15:0] thr);
        start_update(nid, sum, thr);
        tick();
        tick();
        tick();
    endtask

    initial begin
        bus.acc_done    = 1'b0;
        bus.acc_sum     = '0;
        bus.acc_nid     = '0;
        bus.spike_ready = 1'b0;

        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_spike_valid", bus.spike_valid, 0);
        check("rst_spike_nid", bus.spike_nid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_vmem_dbg", vmem_dbg, 0);
        rst_n = 1'b1;
        tick();

        // nid2: 0 -> leak 0 -> +100 = 100 < 200, no spike; busy T+1..T+3
        start_update(3'd2, 16'd100, 16'd200);
        check("u1_busy_t1", busy, 1);
        tick();
        check("u1_busy_t2", busy, 1);
        tick();
        check("u1_busy_t3", busy, 1);
        tick();
        check("u1_busy_t4", busy, 0);
        check("u1_spike_valid", bus.spike_valid, 0);
        check("u1_vmem_dbg", vmem_dbg, 100);

        // nid2: 100 -> 100-12 = 88 -> +120 = 208 >= 200, fires, write back 0
        run_update(3'd2, 16'd120, 16'd200);
        check("u2_spike_valid", bus.spike_valid, 1);
        check("u2_spike_nid", bus.spike_nid, 2);
        check("u2_vmem_dbg", vmem_dbg, 0);
        check("u2_busy_emit", busy, 1);
        bus.spike_ready = 1'b1;
        tick();
        bus.spike_ready = 1'b0;
        check("u2_valid_cleared", bus.spike_valid, 0);
        check("u2_idle", busy, 0);

        // nid2 was reset to 0: 0 + 50 = 50
        run_update(3'd2, 16'd50, 16'd200);
        check("u3_vmem_dbg", vmem_dbg, 50);
        check("u3_spike_valid", bus.spike_valid, 0);

        // Saturation: build vmem[5] = 0xFFF0 without firing
        run_update(3'd5, 16'hFFF0, 16'hFFFF);
        check("sat_pre_vmem_dbg", vmem_dbg, 16'hFFF0);
        check("sat_pre_spike", bus.spike_valid, 0);
        // 0xFFF0 - 0x1FFE = 0xDFF2, + 0xFFFF saturates to 0xFFFF >= 0xFFFF
        run_update(3'd5, 16'hFFFF, 16'hFFFF);
        check("sat_spike_valid", bus.spike_valid, 1);
        check("sat_spike_nid", bus.spike_nid, 5);
        check("sat_vmem_dbg", vmem_dbg, 0);

        // Backpressure: ready low for 5 cycles, acc_done dropped during EMIT
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                bus.acc_done = 1'b1;
                bus.acc_nid  = 3'd5;
                bus.acc_sum  = 16'd1;
            end
            tick();
            bus.acc_done = 1'b0;
            check("bp_spike_valid", bus.spike_valid, 1);
            check("bp_spike_nid", bus.spike_nid, 5);
            check("bp_busy", busy, 1);
        end
        check("bp_overrun", overrun, 1);
        bus.spike_ready = 1'b1;
        tick();
        bus.spike_ready = 1'b0;
        check("bp_valid_cleared", bus.spike_valid, 0);
        check("bp_idle", busy, 0);
        check("bp_overrun_sticky", overrun, 1);
        // Dropped pulse must not have touched vmem[5] (still 0): 0 + 7 = 7
        run_update(3'd5, 16'd7, 16'hFFFF);
        check("bp_vmem_dbg", vmem_dbg, 7);
        check("bp_no_spike", bus.spike_valid, 0);

        // threshold = 0: even a zero result fires
        run_update(3'd1, 16'd0, 16'd0);
        check("thr0_spike_valid", bus.spike_valid, 1);
        check("thr0_spike_nid", bus.spike_nid, 1);
        check("thr0_vmem_dbg", vmem_dbg, 0);
        bus.spike_ready = 1'b1;
        tick();
        bus.spike_ready = 1'b0;
        check("thr0_valid_cleared", bus.spike_valid, 0);

        // clear_all with acc_done in the same IDLE cycle
        run_update(3'd3, 16'd40, 16'd200);
        check("clr_pre_vmem_dbg", vmem_dbg, 40);
        clear_all    = 1'b1;
        bus.acc_done = 1'b1;
        bus.acc_nid  = 3'd3;
        bus.acc_sum  = 16'd5;
        tick();
        clear_all    = 1'b0;
        bus.acc_done = 1'b0;
        check("clr_busy", busy, 0);
        check("clr_overrun", overrun, 0);
        check("clr_spike_valid", bus.spike_valid, 0);
        tick();
        check("clr_still_idle", busy, 0);
        // vmem[3] cleared: 0 + 5 = 5 (uncleared would give 40-5+5 = 40)
        run_update(3'd3, 16'd5, 16'd200);
        check("clr_vmem_dbg", vmem_dbg, 5);

        // Reset while in INTEG aborts the update and clears all state
        start_update(3'd4, 16'd30, 16'd0);
        tick();
        rst_n = 1'b0;
        tick();
        check("mrst_busy", busy, 0);
        check("mrst_spike_valid", bus.spike_valid, 0);
        check("mrst_spike_nid", bus.spike_nid, 0);
        check("mrst_vmem_dbg", vmem_dbg, 0);
        rst_n = 1'b1;
        tick();
        // vmem[2] was 50: after reset 0 + 9 = 9 (else 50-6+9 = 53)
        run_update(3'd2, 16'd9, 16'd200);
        check("mrst_vmem2", vmem_dbg, 9);
        // vmem[5] was 7: after reset 0 + 0 = 0
        run_update(3'd5, 16'd0, 16'hFFFF);
        check("mrst_vmem5", vmem_dbg, 0);
        // vmem[4] must not hold the aborted update: 0 + 2 = 2
        run_update(3'd4, 16'd2, 16'd200);
        check("mrst_vmem4", vmem_dbg, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
